// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - data-memory request/response port between the LSU and memory
interface lsu_mem_port_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - single-outstanding load/store unit with lane alignment and response timeout
module lsu_mem_port #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_start,
    input  logic [3:0]    lsu_ctrl,
    input  logic [63:0]   lsu_addr,
    input  logic [63:0]   lsu_wdata,
    output logic          lsu_busy,
    output logic          lsu_done,
    output logic          lsu_err,
    output logic [63:0]   lsu_rdata,
    lsu_mem_port_if.master mem
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP, S_DONE} state_t;

    localparam logic [9:0] TMO_LAST = 10'(RESP_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [3:0]  ctrl_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        err_q;
    logic [9:0]  cnt_q;
    logic [63:0] rdata_q;

    function automatic logic is_legal(input logic [3:0] c);
        is_legal = (c <= 4'b0110) || (c >= 4'b1000 && c <= 4'b1011);
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] acc_size(input logic [3:0] c);
        case (c)
            4'b0000, 4'b1000:          acc_size = 2'd3;
            4'b0011, 4'b0110, 4'b1001: acc_size = 2'd2;
            4'b0001, 4'b0100, 4'b1010: acc_size = 2'd1;
            default:                   acc_size = 2'd0;
        endcase
    endfunction

    function automatic logic is_signed(input logic [3:0] c);
        is_signed = (c == 4'b0011) || (c == 4'b0100) || (c == 4'b0101);
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
        case (sz)
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = |a[1:0];
            2'd3:    misaligned = |a[2:0];
            default: misaligned = 1'b0;
        endcase
    endfunction

    logic        start_err;
    logic [1:0]  q_size;
    logic        q_store;
    logic [63:0] shifted;
    logic [63:0] load_data;
    logic [7:0]  lane_mask;

    assign start_err = !is_legal(lsu_ctrl) || misaligned(acc_size(lsu_ctrl), lsu_addr[2:0]);
    assign q_size    = acc_size(ctrl_q);
    assign q_store   = ctrl_q[3];
    assign shifted   = mem.mem_resp_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_data = shifted;
        case (q_size)
            2'd0: load_data = is_signed(ctrl_q) ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
            2'd1: load_data = is_signed(ctrl_q) ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
            2'd2: load_data = is_signed(ctrl_q) ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        lane_mask = 8'hFF;
        case (q_size)
            2'd0:    lane_mask = 8'h01 << addr_q[2:0];
            2'd1:    lane_mask = 8'h03 << addr_q[2:0];
            2'd2:    lane_mask = 8'h0F << addr_q[2:0];
            default: lane_mask = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        lsu_busy           = 1'b0;
        lsu_done           = 1'b0;
        lsu_err            = 1'b0;
        mem.mem_req_valid  = 1'b0;
        mem.mem_req_addr   = 64'd0;
        mem.mem_req_wen    = 1'b0;
        mem.mem_req_wdata  = 64'd0;
        mem.mem_req_wmask  = 8'd0;
        case (state)
            S_IDLE: begin
                if (lsu_start) begin
                    state_nxt = start_err ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                lsu_busy          = 1'b1;
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = {addr_q[63:3], 3'b000};
                mem.mem_req_wen   = q_store;
                mem.mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
                mem.mem_req_wmask = q_store ? lane_mask : 8'd0;
                if (mem.mem_req_ready) begin
                    state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                lsu_busy = 1'b1;
                if (mem.mem_resp_valid || cnt_q == TMO_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                lsu_done  = 1'b1;
                lsu_err   = err_q;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A response in the final WAIT_RESP cycle still wins over the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= 4'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            err_q   <= 1'b0;
            cnt_q   <= 10'd0;
            rdata_q <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu_start) begin
                        ctrl_q  <= lsu_ctrl;
                        addr_q  <= lsu_addr;
                        wdata_q <= lsu_wdata;
                        err_q   <= start_err;
                        if (start_err) begin
                            rdata_q <= 64'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready) begin
                        cnt_q <= 10'd0;
                    end
                end
                S_WAIT_RESP: begin
                    if (mem.mem_resp_valid) begin
                        rdata_q <= q_store ? 64'd0 : load_data;
                    end else if (cnt_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        rdata_q <= 64'd0;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu_rdata = rdata_q;
endmodule
